// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, 8 data bits LSB first, then STOP_BITS stop bits.
// Frames match what the board's serial receiver accepts; block holds off new frames.
module serial_tx #(
  parameter int CLK_PER_BIT = 3,
  parameter int STOP_BITS = 1,
  localparam int CTR_SIZE = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  output logic       tx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CTR_SIZE-1:0] CTR_MAX = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [CTR_SIZE-1:0] CTR_ONE = CTR_SIZE'(1);
  // Stop phase counts whole bit periods separately so ctr_reg never widens.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  logic [1:0]          state_reg;
  logic [CTR_SIZE-1:0] ctr_reg;
  logic [2:0]          bit_reg;
  logic [7:0]          shift_reg;
  logic                stop_reg;
  logic                block_q;
  logic                tx_reg;
  logic [2:0]          bit_next;

  assign bit_next = bit_reg + 3'd1;
  assign busy     = (state_reg != IDLE) | block_q;
  assign tx       = tx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ctr_reg   <= '0;
      bit_reg   <= '0;
      stop_reg  <= 1'b0;
      block_q   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      block_q <= block;
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (new_data && !busy) begin
            shift_reg <= data;
            ctr_reg   <= '0;
            bit_reg   <= '0;
            stop_reg  <= 1'b0;
            state_reg <= START;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          tx_reg <= 1'b0;
          if (ctr_reg == CTR_MAX) begin
            ctr_reg   <= '0;
            state_reg <= DATA;
            tx_reg    <= shift_reg[0];
          end else begin
            ctr_reg <= ctr_reg + CTR_ONE;
          end
        end
        DATA: begin
          tx_reg <= shift_reg[bit_reg];
          if (ctr_reg == CTR_MAX) begin
            ctr_reg <= '0;
            if (bit_reg == 3'd7) begin
              bit_reg   <= '0;
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_reg <= bit_next;
              tx_reg  <= shift_reg[bit_next];
            end
          end else begin
            ctr_reg <= ctr_reg + CTR_ONE;
          end
        end
        STOP: begin
          tx_reg <= 1'b1;
          if (ctr_reg == CTR_MAX) begin
            ctr_reg <= '0;
            if (stop_reg == STOP_LAST) begin
              stop_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              stop_reg <= 1'b1;
            end
          end else begin
            ctr_reg <= ctr_reg + CTR_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          ctr_reg   <= '0;
          bit_reg   <= '0;
          stop_reg  <= 1'b0;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one- and two-stop-bit instances share stimulus; each has a
// timeline reference model plus a receiver-style decoder checking the bytes.
module tb_serial_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       block = 1'b0;
  logic [7:0] data = 8'h00;
  logic       new_data = 1'b0;
  logic       bsy [2];
  logic       txo [2];
  logic       armed = 1'b0;
  int         n_checks = 0;
  int         n_fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int SB = gi + 1;
    localparam int FLEN = (9 + SB) * CPB;

    serial_tx #(.CLK_PER_BIT(CPB), .STOP_BITS(SB)) dut (
      .clk(clk), .rst(rst), .block(block), .data(data),
      .new_data(new_data), .busy(bsy[gi]), .tx(txo[gi])
    );

    // Reference: a frame is a timeline of FLEN cycles starting the edge it is accepted.
    int         ecyc = 0;
    int         m_start = 0;
    int         j;
    logic       m_active = 1'b0;
    logic       m_blockq = 1'b0;
    logic       busy_pre;
    logic [7:0] m_byte = 8'h00;
    logic       exp_tx = 1'b1;
    logic       exp_busy = 1'b0;
    logic       rst_hit = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clk) begin
      ecyc++;
      busy_pre = m_active | m_blockq;
      if (rst) begin
        m_active = 1'b0;
        m_blockq = 1'b0;
        exp_q.delete();
        rst_hit = 1'b1;
      end else begin
        if (new_data && !busy_pre) begin
          m_active = 1'b1;
          m_start = ecyc;
          m_byte = data;
          exp_q.push_back(data);
        end else if (m_active && (ecyc - m_start) == FLEN) begin
          m_active = 1'b0;
        end
        m_blockq = block;
      end
      if (m_active) begin
        j = (ecyc - m_start) / CPB;
        if (j == 0) exp_tx = 1'b0;
        else if (j <= 8) exp_tx = m_byte[j-1];
        else exp_tx = 1'b1;
      end else begin
        exp_tx = 1'b1;
      end
      exp_busy = m_active | m_blockq;
    end

    // Receiver model: find the start bit, sample each bit mid-period.
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] want;

    always @(negedge clk) begin
      if (armed) begin
        check($sformatf("tx%0d", gi), 32'(txo[gi]), 32'(exp_tx));
        check($sformatf("busy%0d", gi), 32'(bsy[gi]), 32'(exp_busy));
        if (rst_hit) begin
          rx_busy = 1'b0;
          rst_hit = 1'b0;
        end
        if (!rx_busy) begin
          if (txo[gi] == 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt = 0;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
            rx_byte[rx_cnt / CPB - 1] = txo[gi];
          if (rx_cnt == 9 * CPB + CPB / 2) begin
            rx_busy = 1'b0;
            check($sformatf("stop%0d", gi), 32'(txo[gi]), 32'd1);
            if (exp_q.size() == 0) begin
              check($sformatf("rx_unexpected%0d", gi), 32'(rx_byte), 32'hFFFF_FFFF);
            end else begin
              want = exp_q.pop_front();
              check($sformatf("rx_byte%0d", gi), 32'(rx_byte), 32'(want));
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic wait_free(input int limit);
    int n = 0;
    while (bsy[0] && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_free_timeout", 32'(bsy[0]), 32'd0);
  endtask

  initial begin
    tick(3);
    armed = 1'b1;
    rst = 1'b0;
    tick(100);

    // Single frame 0xA5
    send(8'hA5);
    tick(60);

    // Back-to-back: second strobe in the first non-busy cycle
    send(8'h00);
    tick(2);
    wait_free(100);
    send(8'hFF);
    tick(2);
    wait_free(100);
    tick(20);

    // Strobe during a frame is dropped
    send(8'h55);
    tick(9);
    send(8'h3C);
    wait_free(100);
    tick(20);

    // block raised mid-frame
    send(8'h12);
    tick(10);
    block = 1'b1;
    tick(50);
    send(8'h34);
    tick(5);
    block = 1'b0;
    tick(2);
    send(8'h34);
    tick(2);
    wait_free(100);
    tick(20);

    // Reset 15 cycles into a frame, then 0x81
    send(8'h77);
    tick(14);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send(8'h81);
    tick(70);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      data = 8'($urandom);
      new_data = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) block = ~block;
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    new_data = 1'b0;
    block = 1'b0;
    tick(80);
    check("drain0", 32'(g_inst[0].exp_q.size()), 32'd0);
    check("drain1", 32'(g_inst[1].exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
